// File: rtl/gate_mux_rr_scheduler.sv
// Round-robin scheduler that time-shares one mux-built AND/OR/NOT unit among N requesters.
// Each accepted operation returns after LAT cycles, tagged with the requester index.
module gate_mux_rr_scheduler #(
    parameter  int N   = 4,
    parameter  int W   = 8,
    parameter  int LAT = 2,
    localparam int IDW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [2*N-1:0]   req_op,
    input  logic [N*W-1:0]   req_a,
    input  logic [N*W-1:0]   req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [IDW-1:0]   resp_id,
    output logic [W-1:0]     resp_data,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [IDW-1:0] respId_q, respId_d;
    logic [W-1:0]   respData_q, respData_d;

    logic           grantFound;
    logic [IDW-1:0] grantId;
    logic [IDW-1:0] scanId;
    logic [1:0]     selOp;
    logic [W-1:0]   selA;
    logic [W-1:0]   selB;
    logic [N-1:0]   readyVec;

    // Every result bit is a 2:1 mux selected by the matching bit of a.
    function automatic logic [W-1:0] muxGate(input logic [1:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            case (op)
                2'b00:   r[i] = a[i] ? b[i]  : 1'b0;
                2'b01:   r[i] = a[i] ? 1'b1  : b[i];
                2'b10:   r[i] = a[i] ? 1'b0  : 1'b1;
                default: r[i] = a[i] ? ~b[i] : ~b[i];
            endcase
        end
        return r;
    endfunction

    // Scan ptr, ptr+1, ... (mod N) and pick the first valid requester.
    always_comb begin
        grantFound = 1'b0;
        grantId    = '0;
        scanId     = '0;
        selOp      = '0;
        selA       = '0;
        selB       = '0;
        for (int k = 0; k < N; k++) begin
            scanId = IDW'((int'(ptr_q) + k) % N);
            if (!grantFound && req_valid[scanId]) begin
                grantFound = 1'b1;
                grantId    = scanId;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (grantId == IDW'(i)) begin
                selOp = req_op[2*i +: 2];
                selA  = req_a[i*W +: W];
                selB  = req_b[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        respId_d   = respId_q;
        respData_d = respData_q;
        readyVec   = '0;
        case (state_q)
            IDLE: begin
                if (grantFound) begin
                    readyVec[grantId] = 1'b1;
                    op_d     = selOp;
                    a_d      = selA;
                    b_d      = selB;
                    respId_d = grantId;
                    ptr_d    = IDW'((int'(grantId) + 1) % N);
                    cnt_d    = 4'(LAT - 1);
                    if (LAT > 1) begin
                        state_d = BUSY;
                    end else begin
                        state_d    = RESP;
                        respData_d = muxGate(selOp, selA, selB);
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    respData_d = muxGate(op_q, a_q, b_q);
                end else begin
                    cnt_d = 4'(cnt_q - 4'd1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset wins over any handshake and drops an in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            respId_q   <= '0;
            respData_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            respId_q   <= respId_d;
            respData_q <= respData_d;
        end
    end

    assign req_ready  = readyVec;
    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_id    = respId_q;
    assign resp_data  = respData_q;

endmodule
